// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward scheduler for the 5-stage pipeline with I/D-cache miss FSM and watchdog.
// Outputs are combinational from state and inputs; PIPE_HAZARD_PERF_CNT_EN adds stall-cycle counters.
module pipe_hazard_ctrl #(
   parameter int MISS_TIMEOUT = 256,
   parameter int CNT_W        = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Ihit,
   input  logic       Dhit,
   input  logic [4:0] rsD,
   input  logic [4:0] rtD,
   input  logic [4:0] rsE,
   input  logic [4:0] rtE,
   input  logic [4:0] WriteRegE,
   input  logic [4:0] WriteRegM,
   input  logic [4:0] WriteRegW,
   input  logic       RegWriteE,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       MemtoRegE,
   input  logic       MemtoRegM,
   input  logic       BranchD,
   input  logic       PCSrcD,
   input  logic       JumpD,
   output logic       StallF,
   output logic       StallD,
   output logic       FlushD,
   output logic       EnE,
   output logic       FlushE,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       ForwardAD,
   output logic       ForwardBD,
   output logic       miss_timeout
`ifdef PIPE_HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] perf_istall,
   output logic [CNT_W-1:0] perf_dstall,
   output logic [CNT_W-1:0] perf_hazstall
`endif
);

   localparam logic [1:0] RUN   = 2'd0;
   localparam logic [1:0] IWAIT = 2'd1;
   localparam logic [1:0] DWAIT = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
   logic             lwstall, brstall;

   // Register 0 is hardwired, so it can never create a dependency.
   function automatic logic rmatch(input logic [4:0] a, input logic [4:0] b);
      return (a != 5'd0) && (a == b);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign lwstall = MemtoRegE && (rmatch(rtE, rsD) || rmatch(rtE, rtD));
   assign brstall = BranchD &&
                    ((RegWriteE && (rmatch(WriteRegE, rsD) || rmatch(WriteRegE, rtD))) ||
                     (MemtoRegM && (rmatch(WriteRegM, rsD) || rmatch(WriteRegM, rtD))));

   // Every state shares the same targets: a D-miss dominates, then an I-miss.
   always_comb begin
      state_d = RUN;
      if (!Dhit)      state_d = DWAIT;
      else if (!Ihit) state_d = IWAIT;
   end

   always_comb begin
      cnt_d = '0;
      if (state_d == state_q && state_q != RUN) cnt_d = sat_inc(cnt_q);
      timeout_d = timeout_q || (cnt_d == CNT_W'(MISS_TIMEOUT));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= RUN;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign miss_timeout = timeout_q;

   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b0;
      EnE       = 1'b1;
      FlushE    = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
      if (!reset) begin
         FlushE = 1'b1;
      end else begin
         if (!Dhit) begin
            StallF = 1'b1;
            StallD = 1'b1;
            EnE    = 1'b0;
         end else if (!Ihit || lwstall || brstall) begin
            // Bubble into E while M/W drain; D is held so a redirect re-presents.
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end else if (PCSrcD || JumpD) begin
            FlushD = 1'b1;
         end

         if (RegWriteM && rmatch(WriteRegM, rsE))      ForwardAE = 2'b10;
         else if (RegWriteW && rmatch(WriteRegW, rsE)) ForwardAE = 2'b01;
         if (RegWriteM && rmatch(WriteRegM, rtE))      ForwardBE = 2'b10;
         else if (RegWriteW && rmatch(WriteRegW, rtE)) ForwardBE = 2'b01;
         ForwardAD = RegWriteM && rmatch(WriteRegM, rsD);
         ForwardBD = RegWriteM && rmatch(WriteRegM, rtD);
      end
   end

`ifdef PIPE_HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] istall_q, dstall_q, hazstall_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         istall_q   <= '0;
         dstall_q   <= '0;
         hazstall_q <= '0;
      end else begin
         if (!Dhit)                                  dstall_q   <= sat_inc(dstall_q);
         if (Dhit && !Ihit)                          istall_q   <= sat_inc(istall_q);
         if (Dhit && Ihit && (lwstall || brstall))   hazstall_q <= sat_inc(hazstall_q);
      end
   end

   assign perf_istall   = istall_q;
   assign perf_dstall   = dstall_q;
   assign perf_hazstall = hazstall_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl built with MISS_TIMEOUT = 4.
module tb_pipe_hazard_ctrl;
   logic       clk = 1'b0;
   logic       reset;
   logic       Ihit, Dhit;
   logic [4:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
   logic       BranchD, PCSrcD, JumpD;
   logic       StallF, StallD, FlushD, EnE, FlushE;
   logic [1:0] ForwardAE, ForwardBE;
   logic       ForwardAD, ForwardBD, miss_timeout;
   logic [4:0] ctrl;
   int         checks = 0;
   int         errors = 0;
`ifdef PIPE_HAZARD_PERF_CNT_EN
   logic [31:0] perf_istall, perf_dstall, perf_hazstall;
`endif

   always #5 clk = ~clk;

   // {StallF, StallD, FlushD, EnE, FlushE}
   assign ctrl = {StallF, StallD, FlushD, EnE, FlushE};

   pipe_hazard_ctrl #(.MISS_TIMEOUT(4), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .Ihit(Ihit), .Dhit(Dhit),
      .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
      .BranchD(BranchD), .PCSrcD(PCSrcD), .JumpD(JumpD),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .EnE(EnE), .FlushE(FlushE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
      .miss_timeout(miss_timeout)
`ifdef PIPE_HAZARD_PERF_CNT_EN
      , .perf_istall(perf_istall), .perf_dstall(perf_dstall), .perf_hazstall(perf_hazstall)
`endif
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic setdef();
      Ihit = 1'b1; Dhit = 1'b1;
      rsD = '0; rtD = '0; rsE = '0; rtE = '0;
      WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
      RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
      MemtoRegE = 1'b0; MemtoRegM = 1'b0;
      BranchD = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset overrides hazards, forwards and a D-miss
      reset = 1'b0;
      setdef();
      MemtoRegE = 1'b1; rtE = 5'd2; rsD = 5'd2;
      RegWriteM = 1'b1; WriteRegM = 5'd5; rsE = 5'd5; Dhit = 1'b0;
      #2;
      chk("rst_ctrl", {3'b0, ctrl}, 8'b000_00011);
      chk("rst_fwd", {2'b0, ForwardAE, ForwardBE, ForwardAD, ForwardBD}, 8'h00);
      chk("rst_timeout", {7'b0, miss_timeout}, 8'h00);
      repeat (2) cyc();
      reset = 1'b1;
      setdef();
      #1 chk("run_idle", {3'b0, ctrl}, 8'b000_00010);

      // Load-use stall
      cyc(); setdef(); MemtoRegE = 1'b1; rtE = 5'd2; rsD = 5'd2;
      #1 chk("lw_rs", {3'b0, ctrl}, 8'b000_11011);
      cyc(); MemtoRegE = 1'b0;
      #1 chk("lw_after", {3'b0, ctrl}, 8'b000_00010);
      cyc(); setdef(); MemtoRegE = 1'b1; rtE = 5'd2; rsD = 5'd3; rtD = 5'd2;
      #1 chk("lw_rt", {3'b0, ctrl}, 8'b000_11011);
      cyc(); setdef(); MemtoRegE = 1'b1;
      #1 chk("lw_r0", {3'b0, ctrl}, 8'b000_00010);

      // Forwarding
      cyc(); setdef(); RegWriteM = 1'b1; WriteRegM = 5'd5; RegWriteW = 1'b1; WriteRegW = 5'd5; rsE = 5'd5;
      #1 chk("fae_m", {6'b0, ForwardAE}, 8'd2);
      WriteRegM = 5'd0;
      #1 chk("fae_w", {6'b0, ForwardAE}, 8'd1);
      WriteRegM = 5'd5; rsE = 5'd0; rtE = 5'd5;
      #1 chk("fbe_m", {4'b0, ForwardAE, ForwardBE}, 8'b0000_0010);
      RegWriteW = 1'b0; WriteRegM = 5'd0;
      #1 chk("fbe_none", {6'b0, ForwardBE}, 8'd0);
      cyc(); setdef(); RegWriteM = 1'b1; WriteRegM = 5'd9; rsD = 5'd9;
      #1 chk("fad", {6'b0, ForwardAD, ForwardBD}, 8'b10);
      rsD = 5'd0; rtD = 5'd9;
      #1 chk("fbd", {6'b0, ForwardAD, ForwardBD}, 8'b01);
      RegWriteM = 1'b0;
      #1 chk("fbd_nowr", {6'b0, ForwardAD, ForwardBD}, 8'b00);

      // D-miss for 3 cycles: full freeze, no bubble
      for (int k = 0; k < 3; k++) begin
         cyc(); setdef(); Dhit = 1'b0;
         #1 chk("dmiss", {3'b0, ctrl}, 8'b000_11000);
      end
      cyc(); setdef();
      #1 chk("dmiss_done", {3'b0, ctrl}, 8'b000_00010);
      chk("dmiss_timeout", {7'b0, miss_timeout}, 8'h00);

      // Simultaneous misses, then I-miss with a held redirect
      for (int k = 0; k < 2; k++) begin
         cyc(); setdef(); Ihit = 1'b0; Dhit = 1'b0;
         #1 chk("both_miss", {3'b0, ctrl}, 8'b000_11000);
      end
      for (int k = 0; k < 2; k++) begin
         cyc(); setdef(); Ihit = 1'b0; PCSrcD = 1'b1;
         #1 chk("imiss_redirect", {3'b0, ctrl}, 8'b000_11011);
      end
      cyc(); setdef(); PCSrcD = 1'b1;
      #1 chk("redirect_after", {3'b0, ctrl}, 8'b000_00110);
      chk("both_timeout", {7'b0, miss_timeout}, 8'h00);

      // Watchdog: set after the 4th cycle spent in IWAIT
      cyc(); setdef(); Ihit = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         cyc();
         chk($sformatf("wd_edge%0d", k), {7'b0, miss_timeout}, (k >= 5) ? 8'h01 : 8'h00);
      end
      reset = 1'b0;
      #1 chk("wd_reset", {7'b0, miss_timeout}, 8'h00);
      chk("wd_reset_ctrl", {3'b0, ctrl}, 8'b000_00011);
      cyc(); reset = 1'b1;
      // The wait restarts from RUN after release
      for (int k = 1; k <= 5; k++) begin
         cyc();
         chk($sformatf("wd_restart%0d", k), {7'b0, miss_timeout}, (k >= 5) ? 8'h01 : 8'h00);
      end
      setdef();

      // Branch hazards
      cyc(); setdef(); BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd7; rsD = 5'd7;
      #1 chk("brstall_e", {3'b0, ctrl}, 8'b000_11011);
      cyc(); setdef(); BranchD = 1'b1; PCSrcD = 1'b1; rsD = 5'd7;
      #1 chk("br_taken", {3'b0, ctrl}, 8'b000_00110);
      cyc(); setdef(); BranchD = 1'b1; MemtoRegM = 1'b1; WriteRegM = 5'd4; rtD = 5'd4;
      #1 chk("brstall_m", {3'b0, ctrl}, 8'b000_11011);
      BranchD = 1'b0;
      #1 chk("nobranch", {3'b0, ctrl}, 8'b000_00010);
      cyc(); setdef(); BranchD = 1'b1; RegWriteE = 1'b1;
      #1 chk("br_r0", {3'b0, ctrl}, 8'b000_00010);
      cyc(); setdef(); JumpD = 1'b1;
      #1 chk("jump", {3'b0, ctrl}, 8'b000_00110);

      cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
